// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Brief    : Multi-channel fractional clock-enable generator with settle/lock
//            handling on reset and on run-time ratio reconfiguration.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEF_INC     = 3,
    parameter int DEF_MOD     = 8
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             cfg_valid,
    output logic                                             cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]                                 cfg_inc,
    input  logic [ACC_W-1:0]                                 cfg_mod,
    output logic                                             cfg_err,
    output logic [NUM_CH-1:0]                                ce,
    output logic [NUM_CH-1:0]                                sq,
    output logic [NUM_CH-1:0]                                locked
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0] C_DEF_INC  = ACC_W'(DEF_INC);
    localparam logic [ACC_W-1:0] C_DEF_MOD  = ACC_W'(DEF_MOD);

    generate
        if (!((DEF_INC > 0) && (DEF_INC <= DEF_MOD) && (longint'(DEF_MOD) < (longint'(1) << ACC_W))
              && (NUM_CH >= 1) && (NUM_CH <= 4) && (LOCK_CYCLES >= 2))) begin : g_bad_params
            $error("clk_div_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CH_W-1:0]        r_ch;
    logic [NUM_CH-1:0]      r_locked;
    logic                   r_err;

    logic                   w_cnt_done;
    logic                   w_cfg_ok;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_reject;

    logic [ACC_W:0]         r_acc [NUM_CH];
    logic [ACC_W-1:0]       r_inc [NUM_CH];
    logic [ACC_W-1:0]       r_mod [NUM_CH];
    logic                   r_ce  [NUM_CH];
    logic                   r_sq  [NUM_CH];
    logic [ACC_W:0]         w_sum  [NUM_CH];
    logic [ACC_W:0]         w_diff [NUM_CH];
    logic                   w_wrap [NUM_CH];

    assign w_cnt_done = (r_cnt == C_CNT_LAST);
    assign w_cfg_ok   = (cfg_inc != '0) && (cfg_mod != '0) && (cfg_inc <= cfg_mod)
                        && (32'(cfg_ch) < 32'(NUM_CH));
    assign w_accept   = cfg_valid && cfg_ready;
    assign w_load     = w_accept && w_cfg_ok;
    assign w_reject   = w_accept && !w_cfg_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        case (r_state)
            INIT: begin
                if (w_cnt_done) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                cfg_ready = 1'b1;
                if (cfg_valid && w_cfg_ok) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (w_cnt_done) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Settle counter and lock flags; the target channel is frozen at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_ch     <= '0;
            r_locked <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            case (r_state)
                INIT: begin
                    if (w_cnt_done) begin
                        r_locked <= '1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_cnt <= '0;
                    if (w_load) begin
                        r_ch <= cfg_ch;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (cfg_ch == CH_W'(c)) begin
                                r_locked[c] <= 1'b0;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (w_cnt_done) begin
                        r_cnt <= '0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (r_ch == CH_W'(c)) begin
                                r_locked[c] <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // acc < mod and inc <= mod, so one subtraction always brings the sum back in range.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum[c]  = r_acc[c] + {1'b0, r_inc[c]};
            w_wrap[c] = (w_sum[c] >= {1'b0, r_mod[c]});
            w_diff[c] = w_sum[c] - {1'b0, r_mod[c]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
                r_inc[c] <= C_DEF_INC;
                r_mod[c] <= C_DEF_MOD;
                r_ce[c]  <= 1'b0;
                r_sq[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_load && (cfg_ch == CH_W'(c))) begin
                    r_inc[c] <= cfg_inc;
                    r_mod[c] <= cfg_mod;
                    r_acc[c] <= '0;
                    r_ce[c]  <= 1'b0;
                    r_sq[c]  <= 1'b0;
                end else if (r_locked[c]) begin
                    r_acc[c] <= w_wrap[c] ? w_diff[c] : w_sum[c];
                    r_ce[c]  <= w_wrap[c];
                    r_sq[c]  <= r_sq[c] ^ w_wrap[c];
                end else begin
                    r_acc[c] <= '0;
                    r_ce[c]  <= 1'b0;
                    r_sq[c]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ce[c] = r_ce[c];
            sq[c] = r_sq[c];
        end
    end

    assign locked  = r_locked;
    assign cfg_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Brief    : Randomized self-checking bench for clk_div_gen against a
//            closed-form rate model (pulse k of channel c at floor(t*inc/mod)).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

    localparam int NUM_CH  = 3;
    localparam int ACC_W   = 16;
    localparam int LOCK    = 16;
    localparam int DEF_INC = 3;
    localparam int DEF_MOD = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_mod;
    logic              cfg_err;
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] locked;

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK),
        .DEF_INC     (DEF_INC),
        .DEF_MOD     (DEF_MOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_mod   (cfg_mod),
        .cfg_err   (cfg_err),
        .ce        (ce),
        .sq        (sq),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: channel c locks at cycle m_lock[c]; from then on pulse count is floor(t*inc/mod).
    longint m_inc  [NUM_CH];
    longint m_mod  [NUM_CH];
    longint m_lock [NUM_CH];
    int     m_run;
    bit     m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic longint n_pulses(input int c, input longint t);
        return (t * m_inc[c]) / m_mod[c];
    endfunction

    function automatic logic [NUM_CH-1:0] exp_locked();
        logic [NUM_CH-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = (longint'(cyc) >= m_lock[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ce();
        logic [NUM_CH-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            longint t = longint'(cyc) - m_lock[c];
            if (t >= 1) v[c] = (n_pulses(c, t) != n_pulses(c, t - 1));
        end
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_sq();
        logic [NUM_CH-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            longint t = longint'(cyc) - m_lock[c];
            if (t >= 0) v[c] = n_pulses(c, t) % 2 == 1;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_inc[c]  = DEF_INC;
            m_mod[c]  = DEF_MOD;
            m_lock[c] = LOCK;
        end
        m_run = LOCK;
        m_err = 1'b0;
        cyc   = 0;
    endtask

    // Request sampled at edge cyc is taken if the controller was idle in the preceding cycle.
    task automatic model_edge();
        m_err = 1'b0;
        if (cfg_valid && (cyc - 1 >= m_run)) begin
            if (cfg_inc != 0 && cfg_mod != 0 && cfg_inc <= cfg_mod && int'(cfg_ch) < NUM_CH) begin
                m_inc[cfg_ch]  = cfg_inc;
                m_mod[cfg_ch]  = cfg_mod;
                m_lock[cfg_ch] = cyc + LOCK;
                m_run          = cyc + LOCK;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        longint t0 = longint'(cyc) - m_lock[0];
        check("locked", 32'(locked), 32'(exp_locked()));
        check("ce", 32'(ce), 32'(exp_ce()));
        check("sq", 32'(sq), 32'(exp_sq()));
        check("cfg_ready", 32'(cfg_ready), 32'(cyc >= m_run));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("acc0", 32'(dut.r_acc[0]), (t0 >= 0) ? 32'((t0 * m_inc[0]) % m_mod[0]) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic request(input int ch, input int inc, input int modv, input int hold, input int gap);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_inc   = ACC_W'(inc);
        cfg_mod   = ACC_W'(modv);
        repeat (hold) step();
        cfg_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_ce"}, 32'(ce), 32'd0);
        check({tag, "_sq"}, 32'(sq), 32'd0);
        check({tag, "_ready"}, 32'(cfg_ready), 32'd0);
        check({tag, "_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        int pulses  [NUM_CH];
        int toggles [NUM_CH];
        logic [NUM_CH-1:0] prev_sq;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_inc   = '0;
        cfg_mod   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
        check_all();

        // Default ratio: count pulses and sq toggles over locked cycles t=1..8000.
        for (int c = 0; c < NUM_CH; c++) begin
            pulses[c]  = 0;
            toggles[c] = 0;
        end
        prev_sq = sq;
        for (int i = 0; i < LOCK + 8000; i++) begin
            step();
            if (cyc > LOCK) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    pulses[c]  += int'(ce[c]);
                    toggles[c] += int'(sq[c] != prev_sq[c]);
                end
            end
            prev_sq = sq;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("pulses_ch%0d", c), 32'(pulses[c]), 32'd3000);
            check($sformatf("toggles_ch%0d", c), 32'(toggles[c]), 32'd3000);
        end

        request(1, 1, 4, 1, 40);
        request(0, 5, 4, 1, 3);
        request(1, 0, 4, 1, 3);
        request(3, 1, 2, 1, 3);
        request(0, 2, 5, 40, 20);
        request(2, 7, 7, 1, 30);

        for (int i = 0; i < 30; i++) begin
            request(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    int'($urandom_range(1, 20)), int'($urandom_range(0, 25)));
        end
        repeat (20) step();

        // Reset five cycles into a reconfiguration of channel 1.
        request(1, 1, 2, 1, 5);
        rst = 1'b1;
        #1;
        check_reset_outputs("midsettle_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all();
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
